// File: rtl/ddr_cmd_issuer_pkg.sv
// Shared types and command encodings for the DDR4 command issuer.
// DDR_AUTO_PRECHARGE_EN is consumed by ddr_cmd_issuer, not by this package.
package ddr_package;

    localparam int PKG_ROW_W = 17;
    localparam int PKG_COL_W = 10;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } rw_type;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ACT       = 3'd1,
        WAIT_RCD  = 3'd2,
        CAS       = 3'd3,
        WAIT_DATA = 3'd4,
        BURST     = 3'd5,
        PRE       = 3'd6,
        WAIT_RP   = 3'd7
    } issuer_state_e;

    typedef struct packed {
        rw_type                 rw;
        logic                   bl8;
        logic [1:0]             bg;
        logic [1:0]             ba;
        logic [PKG_ROW_W-1:0]   row;
        logic [PKG_COL_W-1:0]   col;
    } cmd_req_t;

    // {cs_n, act_n, ras_n, cas_n, we_n}; ACT carries row[16:14] in its low three bits
    localparam logic [1:0] CMD_ACT_HI = 2'b00;
    localparam logic [4:0] CMD_WR     = 5'b01100;
    localparam logic [4:0] CMD_RD     = 5'b01101;
    localparam logic [4:0] CMD_PRE    = 5'b01010;
    localparam logic [4:0] CMD_NOP    = 5'b11111;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int sat_load(input int v);
        return (v < 0) ? 0 : v;
    endfunction

endpackage

// File: rtl/ddr_cmd_issuer_timer.sv
// Loadable down-counter used to space DDR commands.
// done: the count reaches zero on this edge; done_next: same, one cycle ahead.
module ddr_cmd_timer
    import ddr_package::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done,
    output logic         done_next
);

    localparam logic [W-1:0] ONE  = W'(1);
    localparam logic [W-1:0] ZERO = W'(0);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    // Next count: load wins, otherwise count down and stick at zero
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != ZERO) begin
            count_d = count_q - ONE;
        end else begin
            count_d = ZERO;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign done      = (count_q <= ONE);
    assign done_next = (count_d <= ONE);

endmodule

// File: rtl/ddr_cmd_issuer.sv
// Issues one ACT -> RD/WR -> PRE sequence per accepted request, closed page.
// Define DDR_AUTO_PRECHARGE_EN to close the row with auto-precharge instead of PRE.
module ddr_cmd_issuer
    import ddr_package::*;
#(
    parameter int T_RCD = 4,
    parameter int T_RP  = 4,
    parameter int CL    = 11,
    parameter int CWL   = 9,
    parameter int ROW_W = 17,
    parameter int COL_W = 10
) (
    input  logic             clock_t,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_rw,
    input  logic             req_bl8,
    input  logic [1:0]       req_bg,
    input  logic [1:0]       req_ba,
    input  logic [ROW_W-1:0] req_row,
    input  logic [COL_W-1:0] req_col,
    output logic             cs_n,
    output logic             act_n,
    output logic             ras_n_a16,
    output logic             cas_n_a15,
    output logic             we_n_a14,
    output logic [1:0]       bg_addr,
    output logic [1:0]       ba_addr,
    output logic             addr13,
    output logic             bc_n_a12,
    output logic             addr11,
    output logic             ap_a10,
    output logic [9:0]       addr9_0,
    output logic             rw_rdy,
    output logic             dimm_rd,
    output logic             busy
);

    localparam int MAXP = max_int(max_int(T_RCD, T_RP), max_int(max_int(CL, CWL), 4));
    localparam int TW   = $clog2(MAXP + 1);

    localparam logic [TW-1:0] LD_RCD   = TW'(sat_load(T_RCD - 1));
    localparam logic [TW-1:0] LD_CL    = TW'(sat_load(CL));
    localparam logic [TW-1:0] LD_CWL   = TW'(sat_load(CWL));
    localparam logic [TW-1:0] LD_BL8   = TW'(sat_load(4 - 1));
    localparam logic [TW-1:0] LD_BC4   = TW'(sat_load(2 - 1));
`ifdef DDR_AUTO_PRECHARGE_EN
    localparam logic [TW-1:0] LD_RP    = TW'(sat_load(T_RP));
    localparam logic          AP_BIT   = 1'b1;
`else
    localparam logic [TW-1:0] LD_RP    = TW'(sat_load(T_RP - 1));
    localparam logic          AP_BIT   = 1'b0;
`endif

    issuer_state_e state_d, state_q;
    cmd_req_t      req_d, req_q, req_in_s;

    logic [4:0]    cmd_d, cmd_q;
    logic [13:0]   addr_d, addr_q;
    logic [1:0]    bg_d, bg_q;
    logic [1:0]    ba_d, ba_q;
    logic          rw_rdy_d, rw_rdy_q;
    logic          dimm_rd_d, dimm_rd_q;
    logic          busy_d, busy_q;
    logic          req_ready_d, req_ready_q;

    logic          accept_s;
    logic          tmr_load_s;
    logic [TW-1:0] tmr_val_s;
    logic          tmr_done_s;
    logic          tmr_done_next_s;

    ddr_cmd_timer #(.W(TW)) u_timer (
        .clk       (clock_t),
        .reset     (reset),
        .load      (tmr_load_s),
        .load_val  (tmr_val_s),
        .done      (tmr_done_s),
        .done_next (tmr_done_next_s)
    );

    // Widen/narrow the incoming request into the package request layout
    always_comb begin
        req_in_s     = '0;
        req_in_s.rw  = rw_type'(req_rw);
        req_in_s.bl8 = req_bl8;
        req_in_s.bg  = req_bg;
        req_in_s.ba  = req_ba;
        req_in_s.row = PKG_ROW_W'(req_row);
        req_in_s.col = PKG_COL_W'(req_col);
    end

    assign accept_s = req_valid && req_ready_q;

    // Next state, request latch and timer loads
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        tmr_load_s = 1'b0;
        tmr_val_s  = '0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    req_d   = req_in_s;
                    state_d = ACT;
                end else begin
                    state_d = IDLE;
                end
            end
            ACT: begin
                tmr_load_s = 1'b1;
                tmr_val_s  = LD_RCD;
                state_d    = WAIT_RCD;
            end
            WAIT_RCD: begin
                if (tmr_done_s) begin
                    state_d = CAS;
                end else begin
                    state_d = WAIT_RCD;
                end
            end
            CAS: begin
                tmr_load_s = 1'b1;
                tmr_val_s  = (req_q.rw == READ) ? LD_CL : LD_CWL;
                state_d    = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (tmr_done_s) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = req_q.bl8 ? LD_BL8 : LD_BC4;
                    state_d    = BURST;
                end else begin
                    state_d = WAIT_DATA;
                end
            end
            BURST: begin
                if (tmr_done_s) begin
`ifdef DDR_AUTO_PRECHARGE_EN
                    tmr_load_s = 1'b1;
                    tmr_val_s  = LD_RP;
                    state_d    = WAIT_RP;
`else
                    state_d    = PRE;
`endif
                end else begin
                    state_d = BURST;
                end
            end
            PRE: begin
                tmr_load_s = 1'b1;
                tmr_val_s  = LD_RP;
                state_d    = WAIT_RP;
            end
            WAIT_RP: begin
                if (tmr_done_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_RP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pin values decoded from the next state so the registered pins line up with state_q
    always_comb begin
        cmd_d       = CMD_NOP;
        addr_d      = 14'd0;
        bg_d        = 2'd0;
        ba_d        = 2'd0;
        case (state_d)
            ACT: begin
                cmd_d  = {CMD_ACT_HI, req_d.row[16:14]};
                addr_d = req_d.row[13:0];
                bg_d   = req_d.bg;
                ba_d   = req_d.ba;
            end
            CAS: begin
                cmd_d  = (req_d.rw == READ) ? CMD_RD : CMD_WR;
                addr_d = {1'b0, req_d.bl8, 1'b0, AP_BIT, req_d.col};
                bg_d   = req_d.bg;
                ba_d   = req_d.ba;
            end
            PRE: begin
                cmd_d  = CMD_PRE;
                bg_d   = req_d.bg;
                ba_d   = req_d.ba;
            end
            default: begin
                cmd_d  = CMD_NOP;
            end
        endcase
        // rw_rdy lands on the last WAIT_DATA cycle, so look one count ahead
        rw_rdy_d    = (state_d == WAIT_DATA) && tmr_done_next_s;
        dimm_rd_d   = rw_rdy_d ? (req_d.rw == READ) : dimm_rd_q;
        busy_d      = (state_d != IDLE);
        req_ready_d = (state_d == IDLE);
    end

    // State, latch and output registers
    always_ff @(posedge clock_t) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= '0;
            cmd_q       <= CMD_NOP;
            addr_q      <= 14'd0;
            bg_q        <= 2'd0;
            ba_q        <= 2'd0;
            rw_rdy_q    <= 1'b0;
            dimm_rd_q   <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            bg_q        <= bg_d;
            ba_q        <= ba_d;
            rw_rdy_q    <= rw_rdy_d;
            dimm_rd_q   <= dimm_rd_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign {cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14} = cmd_q;
    assign {addr13, bc_n_a12, addr11, ap_a10, addr9_0}   = addr_q;
    assign bg_addr   = bg_q;
    assign ba_addr   = ba_q;
    assign rw_rdy    = rw_rdy_q;
    assign dimm_rd   = dimm_rd_q;
    assign busy      = busy_q;
    assign req_ready = req_ready_q;

endmodule

// File: tb/tb_ddr_cmd_issuer.sv
// Scoreboard bench for ddr_cmd_issuer: predicted command/rw_rdy events are
// queued per request and matched against what appears on the DDR pins.
module tb_ddr_cmd_issuer;

    localparam int T_RCD = 4;
    localparam int T_RP  = 4;
    localparam int CL    = 11;
    localparam int CWL   = 9;
    localparam int ROW_W = 17;
    localparam int COL_W = 10;

    localparam logic [4:0] NOP_C = 5'b11111;
    localparam logic [4:0] WR_C  = 5'b01100;
    localparam logic [4:0] RD_C  = 5'b01101;
    localparam logic [4:0] PRE_C = 5'b01010;
`ifdef DDR_AUTO_PRECHARGE_EN
    localparam logic       AP_EXP = 1'b1;
`else
    localparam logic       AP_EXP = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic             req_rw;
    logic             req_bl8;
    logic [1:0]       req_bg;
    logic [1:0]       req_ba;
    logic [ROW_W-1:0] req_row;
    logic [COL_W-1:0] req_col;
    logic             cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14;
    logic [1:0]       bg_addr, ba_addr;
    logic             addr13, bc_n_a12, addr11, ap_a10;
    logic [9:0]       addr9_0;
    logic             rw_rdy, dimm_rd, busy;

    ddr_cmd_issuer #(
        .T_RCD(T_RCD), .T_RP(T_RP), .CL(CL), .CWL(CWL), .ROW_W(ROW_W), .COL_W(COL_W)
    ) dut (
        .clock_t   (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_bl8   (req_bl8),
        .req_bg    (req_bg),
        .req_ba    (req_ba),
        .req_row   (req_row),
        .req_col   (req_col),
        .cs_n      (cs_n),
        .act_n     (act_n),
        .ras_n_a16 (ras_n_a16),
        .cas_n_a15 (cas_n_a15),
        .we_n_a14  (we_n_a14),
        .bg_addr   (bg_addr),
        .ba_addr   (ba_addr),
        .addr13    (addr13),
        .bc_n_a12  (bc_n_a12),
        .addr11    (addr11),
        .ap_a10    (ap_a10),
        .addr9_0   (addr9_0),
        .rw_rdy    (rw_rdy),
        .dimm_rd   (dimm_rd),
        .busy      (busy)
    );

    typedef struct {
        int          cyc;
        bit          is_rdy;
        logic [4:0]  cmd;
        logic [13:0] addr;
        logic [1:0]  bg;
        logic [1:0]  ba;
        logic        rd;
    } ev_t;

    ev_t exp_q[$];
    int  cyc       = 0;
    int  free_cyc  = 0;
    int  n_tests   = 0;
    int  n_fail    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected events for one request whose ACT lands on cycle a
    task automatic push_req(input int a, input logic rw, input logic bl8, input logic [1:0] bg,
                            input logic [1:0] ba, input logic [16:0] row, input logic [9:0] col);
        ev_t e;
        int  lat;
        int  bl;
        lat = rw ? CL : CWL;
        bl  = bl8 ? 4 : 2;
        e = '{cyc: a, is_rdy: 1'b0, cmd: {2'b00, row[16:14]}, addr: row[13:0], bg: bg, ba: ba, rd: 1'b0};
        exp_q.push_back(e);
        e = '{cyc: a + T_RCD, is_rdy: 1'b0, cmd: (rw ? RD_C : WR_C),
              addr: {1'b0, bl8, 1'b0, AP_EXP, col}, bg: bg, ba: ba, rd: 1'b0};
        exp_q.push_back(e);
        e = '{cyc: a + T_RCD + lat, is_rdy: 1'b1, cmd: NOP_C, addr: 14'd0, bg: 2'd0, ba: 2'd0, rd: rw};
        exp_q.push_back(e);
`ifndef DDR_AUTO_PRECHARGE_EN
        e = '{cyc: a + T_RCD + lat + bl, is_rdy: 1'b0, cmd: PRE_C, addr: 14'd0, bg: bg, ba: ba, rd: 1'b0};
        exp_q.push_back(e);
`endif
        free_cyc = a + T_RCD + lat + bl + T_RP;
    endtask

    // Drive a request at the current negedge and hold it until its predicted ACT cycle
    task automatic issue(input logic rw, input logic bl8, input logic [1:0] bg, input logic [1:0] ba,
                         input logic [16:0] row, input logic [9:0] col, output int act);
        act       = ((cyc >= free_cyc) ? cyc : free_cyc) + 1;
        req_valid = 1'b1;
        req_rw    = rw;
        req_bl8   = bl8;
        req_bg    = bg;
        req_ba    = ba;
        req_row   = row;
        req_col   = col;
        push_req(act, rw, bl8, bg, ba, row, col);
        while (cyc < act) @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Match every command / rw_rdy seen on the pins against the queue head
    always @(negedge clk) begin : monitor
        ev_t e;
        if (cyc > 0) begin
            if (cs_n == 1'b0) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_cmd", {27'd0, cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14}, {27'd0, NOP_C});
                end else begin
                    e = exp_q.pop_front();
                    check_val("cmd_cycle", cyc, e.cyc);
                    check_val("cmd_code", {27'd0, cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14}, {27'd0, e.cmd});
                    check_val("cmd_addr", {18'd0, addr13, bc_n_a12, addr11, ap_a10, addr9_0}, {18'd0, e.addr});
                    check_val("cmd_bg_ba", {28'd0, bg_addr, ba_addr}, {28'd0, e.bg, e.ba});
                end
            end
            if (rw_rdy == 1'b1) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_rw_rdy", {31'd0, rw_rdy}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("rdy_event", {31'd0, rw_rdy}, {31'd0, e.is_rdy});
                    check_val("rdy_cycle", cyc, e.cyc);
                    check_val("rdy_dir", {31'd0, dimm_rd}, {31'd0, e.rd});
                end
            end
        end
    end

    initial begin : main
        int   act;
        ev_t  drop;
        reset     = 1'b1;
        req_valid = 1'b1;
        req_rw    = 1'b1;
        req_bl8   = 1'b1;
        req_bg    = 2'd3;
        req_ba    = 2'd3;
        req_row   = 17'h1FFFF;
        req_col   = 10'h3FF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_cs_n", {31'd0, cs_n}, 32'd1);
        check_val("rst_act_n", {31'd0, act_n}, 32'd1);
        check_val("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check_val("rst_rw_rdy", {31'd0, rw_rdy}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_addr", {22'd0, addr9_0}, 32'd0);
        reset     = 1'b0;
        req_valid = 1'b0;
        free_cyc  = cyc + 1;
        @(negedge clk);

        // Write BL8 with the reference addresses
        issue(1'b0, 1'b1, 2'd1, 2'd2, 17'h0ABCD, 10'h155, act);
        check_val("act_req_ready", {31'd0, req_ready}, 32'd0);
        check_val("act_busy", {31'd0, busy}, 32'd1);
        while (cyc < free_cyc) @(negedge clk);
        check_val("idle_req_ready", {31'd0, req_ready}, 32'd1);
        check_val("idle_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check_val("ready_after_idle", {31'd0, req_ready}, 32'd1);
        check_val("wr_dimm_rd_hold", {31'd0, dimm_rd}, 32'd0);

        // Read BC4, column at its maximum
        issue(1'b1, 1'b0, 2'd3, 2'd1, 17'h1F00F, 10'h3FF, act);
        while (cyc < free_cyc) @(negedge clk);
        check_val("rd_dimm_rd_hold", {31'd0, dimm_rd}, 32'd1);

        // Back-to-back: second request held valid from the first ACT onward
        issue(1'b0, 1'b1, 2'd0, 2'd3, 17'h12345, 10'h0AA, act);
        issue(1'b1, 1'b1, 2'd2, 2'd0, 17'h00001, 10'h200, act);
        while (cyc < free_cyc) @(negedge clk);

        // Reset in WAIT_DATA aborts without rw_rdy or PRE
        issue(1'b0, 1'b0, 2'd1, 2'd1, 17'h0F0F0, 10'h011, act);
        while (cyc < act + 8) @(negedge clk);
        reset = 1'b1;
        while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].cyc >= act + 9) drop = exp_q.pop_back();
        @(negedge clk);
        check_val("abort_cs_n", {31'd0, cs_n}, 32'd1);
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        check_val("abort_rw_rdy", {31'd0, rw_rdy}, 32'd0);
        check_val("abort_req_ready", {31'd0, req_ready}, 32'd1);
        reset    = 1'b0;
        free_cyc = cyc + 1;
        repeat (30) @(negedge clk);

        // Recovery after the abort
        issue(1'b1, 1'b1, 2'd2, 2'd2, 17'h15555, 10'h2AA, act);
        while (cyc < free_cyc + 2) @(negedge clk);

        check_val("pending_events", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
